// File: rtl/ddr3_mport_bridge.sv
// Round-robin bridge from NCH cache-side channels onto the DDR3 controller app interface.
// Read beats are steered back to the channel that issued the read via an in-order tag FIFO.
module ddr3_mport_bridge #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned DW   = 128,
  parameter int unsigned AW   = 27,
  parameter int unsigned BW   = 6,
  parameter int unsigned TAGD = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NCH-1:0]            ch_cmd_valid,
  output logic [NCH-1:0]            ch_cmd_ready,
  input  logic [NCH-1:0]            ch_cmd_type,
  input  logic [NCH*AW-1:0]         ch_cmd_addr,
  input  logic [NCH*BW-1:0]         ch_cmd_burst,
  input  logic [NCH-1:0]            ch_wdata_valid,
  output logic [NCH-1:0]            ch_wdata_ready,
  input  logic [NCH*DW-1:0]         ch_wdata,
  input  logic [NCH*DW/8-1:0]       ch_wmask,
  output logic [NCH-1:0]            ch_rsp_valid,
  output logic                      ch_rsp_last,
  output logic [DW-1:0]             ch_rsp_data,
  output logic [2:0]                app_cmd,
  output logic                      app_cmd_en,
  input  logic                      app_cmd_ready,
  output logic [AW-1:0]             app_addr,
  output logic [BW-1:0]             app_burst_number,
  output logic [DW-1:0]             app_wdata,
  output logic [DW/8-1:0]           app_wdata_mask,
  output logic                      app_wdata_en,
  output logic                      app_wdata_end,
  input  logic                      app_wdata_ready,
  input  logic [DW-1:0]             app_rdata,
  input  logic                      app_rdata_valid,
  input  logic                      init_calib_complete,
  output logic                      busy,
  output logic [$clog2(TAGD):0]     rd_outstanding,
  output logic                      err_orphan_rdata
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW = (TAGD > 1) ? $clog2(TAGD) : 1;
  localparam int unsigned OW = $clog2(TAGD) + 1;

  typedef enum logic [1:0] {StIdle, StCmd, StWdata} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   gnt_q, gnt_d, rr_q, rr_d;
  logic [BW-1:0]   burst_q, burst_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d;

  logic [CW-1:0]   tag_ch_q    [TAGD];
  logic [BW-1:0]   tag_burst_q [TAGD];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [OW-1:0]   cnt_q;
  logic            err_q;

  logic            tag_full, tag_empty, push, pop, rd_beat;
  logic [NCH-1:0]  elig;
  logic            any_elig;
  logic [CW-1:0]   pick, idx;
  logic [CW-1:0]   head_ch;
  logic [BW-1:0]   head_burst;

  assign tag_full   = (cnt_q == OW'(TAGD));
  assign tag_empty  = (cnt_q == '0);
  assign head_ch    = tag_ch_q[rptr_q];
  assign head_burst = tag_burst_q[rptr_q];

  // Reads are held off while every tag slot is in use; writes never need a tag.
  always_comb begin
    elig     = ch_cmd_valid & (~ch_cmd_type | {NCH{~tag_full}});
    any_elig = 1'b0;
    pick     = rr_q;
    idx      = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_q) + k) % int'(NCH));
      if (elig[idx]) begin
        pick     = idx;
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    rr_d             = rr_q;
    burst_d          = burst_q;
    wcnt_d           = wcnt_q;
    push             = 1'b0;
    app_cmd_en       = 1'b0;
    app_cmd          = 3'd0;
    app_addr         = '0;
    app_burst_number = '0;
    ch_cmd_ready     = '0;
    ch_wdata_ready   = '0;
    app_wdata        = '0;
    app_wdata_mask   = '0;
    app_wdata_en     = 1'b0;
    app_wdata_end    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init_calib_complete && any_elig) begin
          gnt_d   = pick;
          burst_d = ch_cmd_burst[int'(pick)*BW +: BW];
          rr_d    = (int'(pick) == int'(NCH) - 1) ? '0 : pick + CW'(1);
          state_d = StCmd;
        end
      end
      StCmd: begin
        app_cmd_en       = 1'b1;
        app_cmd          = {2'b00, ch_cmd_type[gnt_q]};
        app_addr         = ch_cmd_addr[int'(gnt_q)*AW +: AW];
        app_burst_number = ch_cmd_burst[int'(gnt_q)*BW +: BW];
        if (app_cmd_ready) begin
          ch_cmd_ready[gnt_q] = 1'b1;
          if (ch_cmd_type[gnt_q]) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            wcnt_d  = '0;
            state_d = StWdata;
          end
        end
      end
      StWdata: begin
        ch_wdata_ready[gnt_q] = app_wdata_ready;
        app_wdata             = ch_wdata[int'(gnt_q)*DW +: DW];
        app_wdata_mask        = ch_wmask[int'(gnt_q)*(DW/8) +: DW/8];
        app_wdata_en          = ch_wdata_valid[gnt_q] & app_wdata_ready;
        if (app_wdata_en) begin
          wcnt_d = wcnt_q + BW'(1);
          if (wcnt_q == burst_q) begin
            app_wdata_end = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read return path is combinational and independent of the command FSM.
  always_comb begin
    rd_beat      = app_rdata_valid & ~tag_empty;
    pop          = rd_beat & (rcnt_q == head_burst);
    ch_rsp_valid = '0;
    if (rd_beat) ch_rsp_valid[head_ch] = 1'b1;
    ch_rsp_data  = rd_beat ? app_rdata : '0;
    ch_rsp_last  = pop;
    rcnt_d       = rcnt_q;
    if (rd_beat) rcnt_d = pop ? '0 : rcnt_q + BW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(TAGD); i++) begin
        tag_ch_q[i]    <= '0;
        tag_burst_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      if (push) begin
        tag_ch_q[wptr_q]    <= gnt_q;
        tag_burst_q[wptr_q] <= burst_q;
        wptr_q <= (wptr_q == PW'(TAGD - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) rptr_q <= (rptr_q == PW'(TAGD - 1)) ? '0 : rptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + OW'(1);
      else if (pop && !push) cnt_q <= cnt_q - OW'(1);
      if (app_rdata_valid && tag_empty) err_q <= 1'b1;
    end
  end

  assign busy             = (state_q != StIdle) || !tag_empty;
  assign rd_outstanding   = cnt_q;
  assign err_orphan_rdata = err_q;

endmodule
